// File: rtl/bbpd_loop_filter_if.sv
// rtl/bbpd_loop_filter_if.sv - PFD sample inputs and DCO control/status outputs of the bang-bang loop filter
interface bbpd_loop_filter_if #(
    parameter int CW = 8
);
    logic          up;
    logic          down;
    logic          en;
    logic [CW-1:0] dco_code;
    logic          dec_up;
    logic          dec_dn;
    logic          slip;
    logic          locked;

    modport master (
        output up, down, en,
        input  dco_code, dec_up, dec_dn, slip, locked
    );

    modport slave (
        input  up, down, en,
        output dco_code, dec_up, dec_dn, slip, locked
    );
endinterface

// File: rtl/bbpd_loop_filter.sv
// rtl/bbpd_loop_filter.sv - bang-bang PFD decision, PI loop filter with saturating DCO word, lock detect
module bbpd_loop_filter #(
    parameter int CW        = 8,
    parameter int FRAC      = 4,
    parameter int KI        = 1,
    parameter int KP        = 4,
    parameter int SLIP_GAIN = 8,
    parameter int INIT_CODE = 128,
    parameter int LOCK_CNT  = 16,
    parameter int MAX_RUN   = 4
) (
    input  logic               ref_clk,
    input  logic               reset_pfd,
    bbpd_loop_filter_if.slave  pfd
);
    localparam int IW = CW + FRAC;
    localparam int SW = IW + 8;
    localparam int OW = CW + 8;
    localparam int AW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(MAX_RUN + 2);

    localparam logic signed [SW-1:0] KI_S   = SW'(KI);
    localparam logic signed [SW-1:0] I_MAX  = SW'((2 ** IW) - 1);
    localparam logic signed [OW-1:0] KP_S   = OW'(KP);
    localparam logic signed [OW-1:0] O_MAX  = OW'((2 ** CW) - 1);
    localparam logic [IW-1:0]        I_INIT = IW'(INIT_CODE) << FRAC;
    localparam logic [AW-1:0]        A_LOCK = AW'(LOCK_CNT);
    localparam logic [RW-1:0]        R_MAX  = RW'(MAX_RUN);
    localparam logic [RW-1:0]        R_SAT  = RW'(MAX_RUN + 1);

    typedef enum logic [1:0] {
        SIGN_NONE,
        SIGN_POS,
        SIGN_NEG
    } sign_e;

    logic          up_s1_q, up_s1_d, up_s2_q, up_s2_d;
    logic          dn_s1_q, dn_s1_d, dn_s2_q, dn_s2_d;
    logic [IW-1:0] integ_q, integ_d;
    logic [CW-1:0] dco_q, dco_d;
    logic          dec_up_q, dec_up_d, dec_dn_q, dec_dn_d, slip_q, slip_d;
    logic          locked_q, locked_d;
    logic [AW-1:0] alt_q, alt_d;
    logic [RW-1:0] run_q, run_d;
    sign_e         prev_q, prev_d;

    logic signed [SW-1:0] d_w;
    logic                 is_pos, is_neg, is_slip;
    logic signed [SW-1:0] integ_sum;
    logic [IW-1:0]        integ_sat;
    logic signed [OW-1:0] out_sum;
    logic [CW-1:0]        out_sat;
    logic [RW-1:0]        run_inc;
    sign_e                cur_sign;

    always_ff @(posedge ref_clk or posedge reset_pfd) begin
        if (reset_pfd) begin
            up_s1_q  <= 1'b0;
            up_s2_q  <= 1'b0;
            dn_s1_q  <= 1'b0;
            dn_s2_q  <= 1'b0;
            integ_q  <= I_INIT;
            dco_q    <= CW'(INIT_CODE);
            dec_up_q <= 1'b0;
            dec_dn_q <= 1'b0;
            slip_q   <= 1'b0;
            locked_q <= 1'b0;
            alt_q    <= '0;
            run_q    <= '0;
            prev_q   <= SIGN_NONE;
        end else begin
            up_s1_q  <= up_s1_d;
            up_s2_q  <= up_s2_d;
            dn_s1_q  <= dn_s1_d;
            dn_s2_q  <= dn_s2_d;
            integ_q  <= integ_d;
            dco_q    <= dco_d;
            dec_up_q <= dec_up_d;
            dec_dn_q <= dec_dn_d;
            slip_q   <= slip_d;
            locked_q <= locked_d;
            alt_q    <= alt_d;
            run_q    <= run_d;
            prev_q   <= prev_d;
        end
    end

    // Synchronizers free-run so the first enabled decision sees settled levels.
    always_comb begin
        up_s1_d = pfd.up;
        up_s2_d = up_s1_q;
        dn_s1_d = pfd.down;
        dn_s2_d = dn_s1_q;
    end

    always_comb begin
        d_w     = '0;
        is_pos  = 1'b0;
        is_neg  = 1'b0;
        is_slip = 1'b0;
        unique case ({up_s2_q, dn_s2_q})
            2'b01: begin d_w = '1;              is_neg  = 1'b1; end
            2'b00: begin d_w = SW'(1);          is_pos  = 1'b1; end
            2'b10: begin d_w = SW'(SLIP_GAIN);  is_slip = 1'b1; end
            default: d_w = '0;
        endcase
    end

    always_comb begin
        integ_sum = $signed({8'd0, integ_q}) + d_w * KI_S;
        if (integ_sum[SW-1])
            integ_sat = '0;
        else if (integ_sum > I_MAX)
            integ_sat = I_MAX[IW-1:0];
        else
            integ_sat = integ_sum[IW-1:0];

        // Proportional kick rides on the freshly updated integrator, no bubble.
        out_sum = $signed({8'd0, integ_sat[IW-1:FRAC]}) + $signed(d_w[OW-1:0]) * KP_S;
        if (out_sum[OW-1])
            out_sat = '0;
        else if (out_sum > O_MAX)
            out_sat = O_MAX[CW-1:0];
        else
            out_sat = out_sum[CW-1:0];

        integ_d  = integ_q;
        dco_d    = integ_q[IW-1:FRAC];
        dec_up_d = 1'b0;
        dec_dn_d = 1'b0;
        slip_d   = 1'b0;
        if (pfd.en) begin
            integ_d  = integ_sat;
            dco_d    = out_sat;
            dec_up_d = is_pos;
            dec_dn_d = is_neg;
            slip_d   = is_slip;
        end
    end

    always_comb begin
        alt_d    = alt_q;
        run_d    = run_q;
        prev_d   = prev_q;
        run_inc  = (run_q == R_SAT) ? run_q : run_q + RW'(1);
        cur_sign = is_neg ? SIGN_NEG : SIGN_POS;
        locked_d = pfd.en && (alt_q == A_LOCK);
        if (!pfd.en) begin
            alt_d  = '0;
            run_d  = '0;
            prev_d = SIGN_NONE;
        end else if (is_slip) begin
            alt_d = '0;
        end else if (is_pos || is_neg) begin
            prev_d = cur_sign;
            if (prev_q == SIGN_NONE) begin
                run_d = RW'(1);
            end else if (prev_q != cur_sign) begin
                run_d = RW'(1);
                if (alt_q != A_LOCK)
                    alt_d = alt_q + AW'(1);
            end else begin
                run_d = run_inc;
                if (run_inc > R_MAX)
                    alt_d = '0;
            end
        end
    end

    assign pfd.dco_code = dco_q;
    assign pfd.dec_up   = dec_up_q;
    assign pfd.dec_dn   = dec_dn_q;
    assign pfd.slip     = slip_q;
    assign pfd.locked   = locked_q;
endmodule

// File: tb/tb_bbpd_loop_filter.sv
// tb/tb_bbpd_loop_filter.sv - directed and random checks of bbpd_loop_filter against an integer reference model
module tb_bbpd_loop_filter;
    localparam int CW        = 8;
    localparam int FRAC      = 4;
    localparam int KI        = 1;
    localparam int KP        = 4;
    localparam int SLIP_GAIN = 8;
    localparam int INIT_CODE = 128;
    localparam int LOCK_CNT  = 16;
    localparam int MAX_RUN   = 4;
    localparam int I_TOP     = (1 << (CW + FRAC)) - 1;
    localparam int O_TOP     = (1 << CW) - 1;

    bit   ref_clk = 1'b0;
    logic reset_pfd;

    bbpd_loop_filter_if #(.CW(CW)) bif ();

    bbpd_loop_filter #(
        .CW(CW), .FRAC(FRAC), .KI(KI), .KP(KP), .SLIP_GAIN(SLIP_GAIN),
        .INIT_CODE(INIT_CODE), .LOCK_CNT(LOCK_CNT), .MAX_RUN(MAX_RUN)
    ) dut (
        .ref_clk   (ref_clk),
        .reset_pfd (reset_pfd),
        .pfd       (bif.slave)
    );

    always #5 ref_clk = ~ref_clk;

    int vectors     = 0;
    int miscompares = 0;

    int m_integ, m_dco, m_alt, m_run, m_prev;
    bit m_up, m_dn, m_slip, m_locked;
    logic [1:0] pipe[$];

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_integ  = INIT_CODE << FRAC;
        m_dco    = INIT_CODE;
        m_alt    = 0;
        m_run    = 0;
        m_prev   = 0;
        m_up     = 0;
        m_dn     = 0;
        m_slip   = 0;
        m_locked = 0;
        pipe     = {2'b00, 2'b00};
    endtask

    // Levels sampled two edges ago drive the decision taken at this edge.
    task automatic model_edge(input bit en);
        logic [1:0] s;
        int d;
        s = pipe.pop_front();
        pipe.push_back({bif.up, bif.down});
        case (s)
            2'b01:   d = -1;
            2'b00:   d = 1;
            2'b10:   d = SLIP_GAIN;
            default: d = 0;
        endcase
        m_locked = en && (m_alt == LOCK_CNT);
        if (en) begin
            m_integ = clamp(m_integ + d * KI, 0, I_TOP);
            m_dco   = clamp(m_integ / (1 << FRAC) + d * KP, 0, O_TOP);
            m_up    = (d == 1);
            m_dn    = (d == -1);
            m_slip  = (s == 2'b10);
        end else begin
            m_dco  = m_integ / (1 << FRAC);
            m_up   = 0;
            m_dn   = 0;
            m_slip = 0;
        end
        if (!en) begin
            m_alt  = 0;
            m_run  = 0;
            m_prev = 0;
        end else if (s == 2'b10) begin
            m_alt = 0;
        end else if (d == 1 || d == -1) begin
            if (m_prev == 0) begin
                m_run = 1;
            end else if (m_prev != d) begin
                m_run = 1;
                if (m_alt < LOCK_CNT) m_alt++;
            end else begin
                m_run++;
                if (m_run > MAX_RUN) m_alt = 0;
            end
            m_prev = d;
        end
    endtask

    task automatic check_outputs(input string tag);
        vectors++;
        assert (bif.dco_code === CW'(m_dco)) else begin
            miscompares++;
            $error("FAIL %s dco_code got %0d exp %0d", tag, bif.dco_code, m_dco);
        end
        assert (bif.dec_up === m_up) else begin
            miscompares++;
            $error("FAIL %s dec_up got %0b exp %0b", tag, bif.dec_up, m_up);
        end
        assert (bif.dec_dn === m_dn) else begin
            miscompares++;
            $error("FAIL %s dec_dn got %0b exp %0b", tag, bif.dec_dn, m_dn);
        end
        assert (bif.slip === m_slip) else begin
            miscompares++;
            $error("FAIL %s slip got %0b exp %0b", tag, bif.slip, m_slip);
        end
        assert (bif.locked === m_locked) else begin
            miscompares++;
            $error("FAIL %s locked got %0b exp %0b", tag, bif.locked, m_locked);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit u, input bit dn, input bit e, input string tag);
        bif.up   = u;
        bif.down = dn;
        bif.en   = e;
        @(posedge ref_clk);
        model_edge(e);
        #1;
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_dco"}, int'(bif.dco_code), INIT_CODE);
        check_val({tag, "_pulses"}, int'({bif.dec_up, bif.dec_dn, bif.slip, bif.locked}), 0);
    endtask

    task automatic do_reset();
        #2;
        reset_pfd = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge ref_clk);
        #1;
        reset_pfd = 1'b0;
        model_reset();
    endtask

    initial begin
        int held;
        bit tog;
        int r;
        reset_pfd = 1'b1;
        bif.up    = 1'b0;
        bif.down  = 1'b0;
        bif.en    = 1'b0;
        #1;
        check_reset_state("por");
        @(posedge ref_clk);
        #1;
        reset_pfd = 1'b0;
        model_reset();

        // constant early: prime synchronizers, then 16 enabled -1 decisions
        step(0, 1, 0, "early_prime");
        step(0, 1, 0, "early_prime");
        for (int i = 0; i < 16; i++) step(0, 1, 1, "early");
        check_val("early_dco", int'(bif.dco_code), 123);
        check_val("early_dec_dn", int'(bif.dec_dn), 1);

        // asynchronous reset with dco away from INIT_CODE
        do_reset();

        // one late decision, then one slip
        step(0, 0, 0, "ls_idle");
        step(1, 0, 0, "ls_idle");
        step(0, 0, 1, "late");
        check_val("late_dco", int'(bif.dco_code), 132);
        step(0, 0, 1, "slip");
        check_val("slip_dco", int'(bif.dco_code), 160);
        check_val("slip_pulse", int'(bif.slip), 1);

        // upper rail, then lower rail
        for (int i = 0; i < 300; i++) step(1, 0, 1, "sat_hi");
        check_val("sat_hi_dco", int'(bif.dco_code), 255);
        for (int i = 0; i < 4200; i++) step(0, 1, 1, "sat_lo");
        check_val("sat_lo_dco", int'(bif.dco_code), 0);

        // lock by alternation, then break it with a long +1 run
        do_reset();
        for (int i = 0; i < 24; i++) step(0, (i % 2) == 0, 1, "lock_alt");
        check_val("lock_set", int'(bif.locked), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, "lock_run");
        check_val("lock_drop", int'(bif.locked), 0);

        // disabled activity, then hold decisions
        for (int i = 0; i < 12; i++) step(1'($urandom), 1'($urandom), 0, "en_off");
        step(1, 1, 0, "hold_prime");
        step(1, 1, 0, "hold_prime");
        held = m_dco;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, "hold");
            check_val("hold_dco", int'(bif.dco_code), held);
            check_val("hold_pulses", int'({bif.dec_up, bif.dec_dn, bif.slip}), 0);
        end

        // random mix of near-alternating decisions, rare slips/holds, occasional disable
        tog = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 63));
            if (($urandom % 4) != 0) tog = ~tog;
            if (r == 0)      step(1, 0, ($urandom % 32) != 0, "rand");
            else if (r == 1) step(1, 1, ($urandom % 32) != 0, "rand");
            else             step(0, tog, ($urandom % 32) != 0, "rand");
        end

        do_reset();
        step(0, 0, 1, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
